// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Holds the FSM state enum, the 100 MHz dwell default and a width helper.
package seg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // 10 ms at 100 MHz keeps a digit pair on screen long enough to read.
    localparam int DEF_DWELL = 1_000_000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first asserted request
// found searching upward from ptr, wrapping from NREQ-1 back to 0.
module rr_pick
    import seg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        // Walk from the farthest candidate down so the nearest one to ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                any = 1'b1;
                idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a shared 2-digit 7-segment driver; each grant lasts
// a multiple of DWELL cycles and the display blanks when nobody requests.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int DWELL = DEF_DWELL,
    localparam int PW   = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] val,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   owner,
    output logic [W-1:0]    disp_value,
    output logic            disp_blank,
    output state_t          dbg_state
);

    localparam int           CW       = clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [PW-1:0]   r_owner;
    logic [W-1:0]    r_val;
    logic            r_blank;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    logic            w_any;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_onehot;
    logic [W-1:0]    w_win_val;
    logic [W-1:0]    w_own_val;

    // One encoder serves both the IDLE pick and the HOLD-expiry pick: with
    // ptr = owner+1 the owner is searched last, so it only re-wins when alone.
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_ptr_nxt = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + PW'(1);
    assign w_onehot  = NREQ'(1) << w_idx;
    assign w_win_val = val[int'(w_idx) * W +: W];
    assign w_own_val = val[int'(r_owner) * W +: W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_val   <= '0;
            r_blank <= 1'b1;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= HOLD;
                        r_gnt   <= w_onehot;
                        r_owner <= w_idx;
                        r_val   <= w_win_val;
                        r_blank <= 1'b0;
                        r_ptr   <= w_ptr_nxt;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                        r_val <= w_own_val;
                    end else if (w_any) begin
                        // Back-to-back handoff (or owner re-grant): no gap cycle.
                        r_gnt   <= w_onehot;
                        r_owner <= w_idx;
                        r_val   <= w_win_val;
                        r_ptr   <= w_ptr_nxt;
                        r_cnt   <= CNT_LOAD;
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_blank <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign owner      = r_owner;
    assign disp_value = r_val;
    assign disp_blank = r_blank;
    assign dbg_state  = r_state;

endmodule
